// File: rtl/fp_mul_result_stage.sv
// Registered output stage for the FP multiplier: exception encoding, two-entry skid buffer,
// sticky flags and saturating counters. Define FP_RESULT_NAN_CANON_EN to canonicalise NaNs.
module fp_mul_result_stage #(
    parameter int EXP_WIDTH      = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  valid_in,
    output logic                                  ready_out,
    input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     fpm_in,
    input  logic                                  overflow_in,
    input  logic                                  underflow_in,
    output logic                                  valid_out,
    input  logic                                  ready_in,
    output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     result_out,
    output logic                                  ovf_out,
    output logic                                  unf_out,
    input  logic                                  sticky_clr_in,
    output logic                                  sticky_ovf_out,
    output logic                                  sticky_unf_out,
    output logic [CNT_WIDTH-1:0]                  ovf_count_out,
    output logic [CNT_WIDTH-1:0]                  unf_count_out
);

    localparam int W = EXP_WIDTH + MANTISSA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Buffer entries carry {ovf, unf, data} so the flags always travel with their result.
    logic [W+1:0] enc_entry;
    logic [W-1:0] enc_data;
    logic         enc_ovf;
    logic         enc_unf;

    logic [W+1:0] main_entry, main_entry_nxt;
    logic [W+1:0] skid_entry, skid_entry_nxt;
    logic         main_valid, main_valid_nxt;
    logic         skid_valid, skid_valid_nxt;

    logic accept;
    logic drain;
    logic acc_ovf;
    logic acc_unf;

    logic [EXP_WIDTH-1:0]      in_exp;
    logic [MANTISSA_WIDTH-1:0] in_mant;

    assign in_exp  = fpm_in[W-2 -: EXP_WIDTH];
    assign in_mant = fpm_in[MANTISSA_WIDTH-1:0];

    always_comb begin
        enc_data = fpm_in;
        enc_ovf  = 1'b0;
        enc_unf  = 1'b0;
        if (overflow_in) begin
            enc_data = {fpm_in[W-1], {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
            enc_ovf  = 1'b1;
        end else if (underflow_in) begin
            enc_data = {fpm_in[W-1], {(W-1){1'b0}}};
            enc_unf  = 1'b1;
        end
`ifdef FP_RESULT_NAN_CANON_EN
        else if ((in_exp == {EXP_WIDTH{1'b1}}) && (in_mant != '0)) begin
            enc_data = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANTISSA_WIDTH-1){1'b0}}};
        end
`endif
    end

    assign enc_entry = {enc_ovf, enc_unf, enc_data};

    assign accept  = valid_in & ready_out;
    assign drain   = main_valid & ready_in;
    assign acc_ovf = accept & enc_ovf;
    assign acc_unf = accept & enc_unf;

    // The skid register is only ever occupied while main is, and ready_out blocks accepts
    // whenever skid is full, so a drain with a full skid never coincides with an accept.
    always_comb begin
        main_entry_nxt = main_entry;
        main_valid_nxt = main_valid;
        skid_entry_nxt = skid_entry;
        skid_valid_nxt = skid_valid;
        if (drain) begin
            if (skid_valid) begin
                main_entry_nxt = skid_entry;
                skid_valid_nxt = 1'b0;
            end else if (accept) begin
                main_entry_nxt = enc_entry;
            end else begin
                main_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_entry_nxt = enc_entry;
                skid_valid_nxt = 1'b1;
            end else begin
                main_entry_nxt = enc_entry;
                main_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            main_entry <= '0;
            main_valid <= 1'b0;
            skid_entry <= '0;
            skid_valid <= 1'b0;
            ready_out  <= 1'b0;
        end else begin
            main_entry <= main_entry_nxt;
            main_valid <= main_valid_nxt;
            skid_entry <= skid_entry_nxt;
            skid_valid <= skid_valid_nxt;
            ready_out  <= ~skid_valid_nxt;
        end
    end

    // A clear in the same cycle as an accepted event leaves that event recorded.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sticky_ovf_out <= 1'b0;
            sticky_unf_out <= 1'b0;
            ovf_count_out  <= '0;
            unf_count_out  <= '0;
        end else if (sticky_clr_in) begin
            sticky_ovf_out <= acc_ovf;
            sticky_unf_out <= acc_unf;
            ovf_count_out  <= acc_ovf ? CNT_ONE : '0;
            unf_count_out  <= acc_unf ? CNT_ONE : '0;
        end else begin
            if (acc_ovf) begin
                sticky_ovf_out <= 1'b1;
                if (ovf_count_out != {CNT_WIDTH{1'b1}}) ovf_count_out <= ovf_count_out + CNT_ONE;
            end
            if (acc_unf) begin
                sticky_unf_out <= 1'b1;
                if (unf_count_out != {CNT_WIDTH{1'b1}}) unf_count_out <= unf_count_out + CNT_ONE;
            end
        end
    end

    assign valid_out  = main_valid;
    assign result_out = main_entry[W-1:0];
    assign ovf_out    = main_entry[W+1];
    assign unf_out    = main_entry[W];

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Directed bench for fp_mul_result_stage: a default-width instance plus a CNT_WIDTH=2 instance
// driven in parallel to exercise counter saturation.
module tb_fp_mul_result_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] fpm_in;
    logic        overflow_in;
    logic        underflow_in;
    logic        sticky_clr_in;

    logic        ready_out, valid_out, ovf_out, unf_out, sticky_ovf_out, sticky_unf_out;
    logic [31:0] result_out;
    logic [15:0] ovf_count_out, unf_count_out;

    logic        s_ready_out, s_valid_out, s_ovf_out, s_unf_out, s_sticky_ovf_out, s_sticky_unf_out;
    logic [31:0] s_result_out;
    logic [1:0]  s_ovf_count_out, s_unf_count_out;

    int check_count = 0;
    int error_count = 0;

    always #5 clk_in = ~clk_in;

    fp_mul_result_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .fpm_in(fpm_in), .overflow_in(overflow_in), .underflow_in(underflow_in),
        .valid_out(valid_out), .ready_in(ready_in), .result_out(result_out),
        .ovf_out(ovf_out), .unf_out(unf_out), .sticky_clr_in(sticky_clr_in),
        .sticky_ovf_out(sticky_ovf_out), .sticky_unf_out(sticky_unf_out),
        .ovf_count_out(ovf_count_out), .unf_count_out(unf_count_out)
    );

    fp_mul_result_stage #(.CNT_WIDTH(2)) dut_small (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(s_ready_out),
        .fpm_in(fpm_in), .overflow_in(overflow_in), .underflow_in(underflow_in),
        .valid_out(s_valid_out), .ready_in(ready_in), .result_out(s_result_out),
        .ovf_out(s_ovf_out), .unf_out(s_unf_out), .sticky_clr_in(sticky_clr_in),
        .sticky_ovf_out(s_sticky_ovf_out), .sticky_unf_out(s_sticky_unf_out),
        .ovf_count_out(s_ovf_count_out), .unf_count_out(s_unf_count_out)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] data, input logic ovf, input logic unf);
        valid_in     = v;
        fpm_in       = data;
        overflow_in  = ovf;
        underflow_in = unf;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1;
        ready_in = 1'b1;
        sticky_clr_in = 1'b0;
        applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_ready", ready_out, 0);
        checkOutput("reset_valid", valid_out, 0);
        checkOutput("reset_result", result_out, 0);
        checkOutput("reset_flags", {ovf_out, unf_out, sticky_ovf_out, sticky_unf_out}, 0);
        checkOutput("reset_counts", {ovf_count_out, unf_count_out}, 0);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst_in = 1'b0;
        tick();
        checkOutput("ready_after_reset", ready_out, 1);
        checkOutput("valid_after_reset", valid_out, 0);

        applyStimulus(1'b1, 32'h40400000, 1'b0, 1'b0);
        tick();
        checkOutput("pass_valid", valid_out, 1);
        checkOutput("pass_result", result_out, 32'h40400000);
        checkOutput("pass_flags", {ovf_out, unf_out}, 0);

        applyStimulus(1'b1, 32'hBF800000, 1'b1, 1'b0);
        tick();
        checkOutput("ovf_result", result_out, 32'hFF800000);
        checkOutput("ovf_flags", {ovf_out, unf_out}, 2'b10);
        checkOutput("ovf_sticky", sticky_ovf_out, 1);
        checkOutput("ovf_count", ovf_count_out, 1);

        applyStimulus(1'b1, 32'h00A00000, 1'b0, 1'b1);
        tick();
        checkOutput("unf_result", result_out, 32'h00000000);
        checkOutput("unf_flags", {ovf_out, unf_out}, 2'b01);
        checkOutput("unf_sticky", sticky_unf_out, 1);
        checkOutput("unf_count", unf_count_out, 1);

        applyStimulus(1'b1, 32'h3F800000, 1'b1, 1'b1);
        tick();
        checkOutput("both_result", result_out, 32'h7F800000);
        checkOutput("both_flags", {ovf_out, unf_out}, 2'b10);
        checkOutput("both_ovf_count", ovf_count_out, 2);

        applyStimulus(1'b1, 32'hFFC00001, 1'b0, 1'b0);
        tick();
`ifdef FP_RESULT_NAN_CANON_EN
        checkOutput("nan_result", result_out, 32'h7FC00000);
`else
        checkOutput("nan_result", result_out, 32'hFFC00001);
`endif
        checkOutput("nan_flags", {ovf_out, unf_out}, 0);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("drain_valid", valid_out, 0);

        sticky_clr_in = 1'b1;
        tick();
        checkOutput("clr_flags", {sticky_ovf_out, sticky_unf_out, s_sticky_ovf_out}, 0);
        checkOutput("clr_counts", {ovf_count_out, unf_count_out, s_ovf_count_out}, 0);

        applyStimulus(1'b1, 32'h40000000, 1'b1, 1'b0);
        tick();
        checkOutput("clr_evt_sticky", {sticky_ovf_out, sticky_unf_out}, 2'b10);
        checkOutput("clr_evt_count", ovf_count_out, 1);
        checkOutput("clr_evt_unf_count", unf_count_out, 0);

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        sticky_clr_in = 1'b0;
        checkOutput("clr_again_count", ovf_count_out, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h40000000 + i, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("sat_big_count", ovf_count_out, 5);
        checkOutput("sat_small_count", s_ovf_count_out, 3);
        tick();

        ready_in = 1'b0;
        applyStimulus(1'b1, 32'h3F800000, 1'b0, 1'b0);
        tick();
        checkOutput("bp_a_result", result_out, 32'h3F800000);
        checkOutput("bp_a_ready", ready_out, 1);
        applyStimulus(1'b1, 32'h40000000, 1'b0, 1'b0);
        tick();
        checkOutput("bp_b_ready", ready_out, 0);
        checkOutput("bp_b_hold", result_out, 32'h3F800000);
        applyStimulus(1'b1, 32'h40400000, 1'b0, 1'b0);
        tick();
        checkOutput("bp_c_hold", {valid_out, result_out}, {1'b1, 32'h3F800000});
        checkOutput("bp_c_ready", ready_out, 0);
        ready_in = 1'b1;
        tick();
        checkOutput("bp_out_b", result_out, 32'h40000000);
        checkOutput("bp_ready_back", ready_out, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("bp_out_c", {valid_out, result_out}, {1'b1, 32'h40400000});
        tick();
        checkOutput("bp_empty", valid_out, 0);

        ready_in = 1'b0;
        applyStimulus(1'b1, 32'hBF800000, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00A00000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst_in = 1'b1;
        tick();
        checkOutput("midrst_valid", {valid_out, ready_out}, 0);
        checkOutput("midrst_result", result_out, 0);
        checkOutput("midrst_sticky", {sticky_ovf_out, sticky_unf_out, ovf_count_out, unf_count_out}, 0);
        rst_in = 1'b0;
        ready_in = 1'b1;
        tick();
        checkOutput("midrst_recover", {valid_out, ready_out}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
